// File: rtl/daq_pkg.sv
// Shared types and constants for the ADC acquisition path. The command
// interpreter uses the same channel-select encodings.
package daq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WAIT,
        S_CH1,
        S_CH2
    } state_t;

    localparam logic [3:0]  TAG_CH1             = 4'h1;
    localparam logic [3:0]  TAG_CH2             = 4'h2;
    localparam logic [15:0] HEADER_WORD_DEFAULT = 16'hAA55;

    localparam logic [1:0] CH_OFF  = 2'b00;
    localparam logic [1:0] CH1     = 2'b01;
    localparam logic [1:0] CH2     = 2'b10;
    localparam logic [1:0] CH_BOTH = 2'b11;

    // The sample is already right-aligned and zero-extended to 12 bits.
    function automatic logic [15:0] pack_word(input logic [3:0] tag, input logic [11:0] sample);
        return {tag, sample};
    endfunction

endpackage

// File: rtl/adc_data_packer.sv
// Packs dual-channel ADC samples into tagged 16-bit words, frames them behind
// a header word and writes them to the USB upload FIFO, counting dropped samples.
module adc_data_packer
    import daq_pkg::*;
#(
    parameter int          ADC_WIDTH   = 12,
    parameter int          FRAME_LEN   = 256,
    parameter logic [15:0] HEADER_WORD = HEADER_WORD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           Channel_Select,
    input  logic                 rst_fifo_req,
    input  logic                 adc_valid,
    input  logic [ADC_WIDTH-1:0] adc_ch1_data,
    input  logic [ADC_WIDTH-1:0] adc_ch2_data,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic [15:0]          fifo_din,
    output logic [15:0]          overflow_cnt,
    output logic                 busy
);

    localparam int CNT_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

    state_t                 state;
    logic [1:0]             mode;
    logic [CNT_W-1:0]       sample_cnt;
    logic [ADC_WIDTH-1:0]   hold_ch1;
    logic [ADC_WIDTH-1:0]   hold_ch2;

    logic last_sample;
    logic drop;

    assign last_sample = (sample_cnt == CNT_W'(FRAME_LEN - 1));
    // A strobe arriving while a word is still pending is lost; the held pair is kept.
    assign drop        = adc_valid && (state == S_HDR || state == S_CH1 || state == S_CH2);
    assign busy        = (state != S_IDLE);

    // FIFO write handshake: a word is transferred on every cycle fifo_wr_en is
    // high. The write is decided from fifo_full at the edge before it appears,
    // and nothing is issued on an edge that sees fifo_full=1; almost-full
    // guarantees room for that one in-flight word.
    always_ff @(posedge clk) begin
        if (!reset_n || rst_fifo_req) begin
            state        <= S_IDLE;
            mode         <= CH_OFF;
            sample_cnt   <= '0;
            hold_ch1     <= '0;
            hold_ch2     <= '0;
            fifo_wr_en   <= 1'b0;
            fifo_din     <= '0;
            overflow_cnt <= '0;
        end else begin
            fifo_wr_en <= 1'b0;

            if (drop && overflow_cnt != 16'hFFFF)
                overflow_cnt <= overflow_cnt + 16'd1;

            case (state)
                S_IDLE: begin
                    mode <= Channel_Select;
                    if (Channel_Select != CH_OFF)
                        state <= S_HDR;
                end
                S_HDR: begin
                    if (!fifo_full) begin
                        fifo_wr_en <= 1'b1;
                        fifo_din   <= HEADER_WORD;
                        sample_cnt <= '0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (adc_valid) begin
                        hold_ch1 <= adc_ch1_data;
                        hold_ch2 <= adc_ch2_data;
                        state    <= mode[0] ? S_CH1 : S_CH2;
                    end
                end
                S_CH1: begin
                    if (!fifo_full) begin
                        fifo_wr_en <= 1'b1;
                        fifo_din   <= pack_word(TAG_CH1, 12'(hold_ch1));
                        if (mode[1])
                            state <= S_CH2;
                        else if (last_sample)
                            state <= S_IDLE;
                        else begin
                            sample_cnt <= sample_cnt + 1'b1;
                            state      <= S_WAIT;
                        end
                    end
                end
                S_CH2: begin
                    if (!fifo_full) begin
                        fifo_wr_en <= 1'b1;
                        fifo_din   <= pack_word(TAG_CH2, 12'(hold_ch2));
                        if (last_sample)
                            state <= S_IDLE;
                        else begin
                            sample_cnt <= sample_cnt + 1'b1;
                            state      <= S_WAIT;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_data_packer.sv
// Directed bench for adc_data_packer with a 4-sample frame; every FIFO write
// is matched against an expected-word queue.
module tb_adc_data_packer;

    logic        clk;
    logic        reset_n;
    logic [1:0]  Channel_Select;
    logic        rst_fifo_req;
    logic        adc_valid;
    logic [11:0] adc_ch1_data;
    logic [11:0] adc_ch2_data;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [15:0] fifo_din;
    logic [15:0] overflow_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    logic [15:0] exp_q[$];

    adc_data_packer #(
        .ADC_WIDTH  (12),
        .FRAME_LEN  (4),
        .HEADER_WORD(16'hAA55)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .Channel_Select(Channel_Select),
        .rst_fifo_req  (rst_fifo_req),
        .adc_valid     (adc_valid),
        .adc_ch1_data  (adc_ch1_data),
        .adc_ch2_data  (adc_ch2_data),
        .fifo_full     (fifo_full),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_din      (fifo_din),
        .overflow_cnt  (overflow_cnt),
        .busy          (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: every write must match the head of exp_q
    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            wr_count++;
            if (exp_q.size() > 0)
                check("fifo_word", {16'h0, fifo_din}, {16'h0, exp_q.pop_front()});
            else
                check("unexpected_write", {16'h0, fifo_din}, 32'hxxxx_xxxx);
        end
    end

    // driver tasks
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        Channel_Select = 2'b00;
        rst_fifo_req   = 1'b0;
        adc_valid      = 1'b0;
        fifo_full      = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    // adc_valid is seen at the very next rising edge
    task automatic adc_strobe(input logic [11:0] c1, input logic [11:0] c2);
        adc_ch1_data = c1;
        adc_ch2_data = c2;
        adc_valid    = 1'b1;
        tick(1);
        adc_valid    = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    logic busy_seen;
    int   wr_before;

    initial begin
        adc_ch1_data = '0;
        adc_ch2_data = '0;

        // reset state
        do_reset();
        @(negedge clk);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_din", fifo_din, 0);
        check("rst_ovf", overflow_cnt, 0);
        check("rst_busy", busy, 0);

        // ch1 only, one full frame then the next header
        do_reset();
        Channel_Select = 2'b01;
        exp_q.push_back(16'hAA55);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h1123);
        exp_q.push_back(16'hAA55);
        exp_q.push_back(16'h1123);
        tick(2);
        for (int i = 0; i < 5; i++) begin
            adc_strobe(12'h123, 12'h456);
            tick(3);
        end
        drain_check("t1_drain");
        check("t1_ovf", overflow_cnt, 0);

        // both channels, latency of the two data words
        do_reset();
        Channel_Select = 2'b11;
        exp_q.push_back(16'hAA55);
        exp_q.push_back(16'h10AB);
        exp_q.push_back(16'h2FFF);
        tick(2);
        adc_strobe(12'h0AB, 12'hFFF);
        @(negedge clk);
        check("t2_n_wr_en", fifo_wr_en, 0);
        tick(1);
        @(negedge clk);
        check("t2_n1_wr_en", fifo_wr_en, 1);
        check("t2_n1_din", fifo_din, 16'h10AB);
        tick(1);
        @(negedge clk);
        check("t2_n2_wr_en", fifo_wr_en, 1);
        check("t2_n2_din", fifo_din, 16'h2FFF);
        tick(2);
        drain_check("t2_drain");
        check("t2_ovf", overflow_cnt, 0);

        // channels off: nothing written, nothing counted
        do_reset();
        wr_before = wr_count;
        busy_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            adc_strobe(12'(i), 12'(~i));
            @(negedge clk);
            busy_seen = busy_seen | busy;
            tick(3);
        end
        check("t3_writes", wr_count - wr_before, 0);
        check("t3_busy", busy_seen, 0);
        check("t3_ovf", overflow_cnt, 0);

        // backpressure in S_CH1: three strobes dropped, held pair survives
        do_reset();
        Channel_Select = 2'b11;
        exp_q.push_back(16'hAA55);
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        exp_q.push_back(16'h1555);
        exp_q.push_back(16'h2666);
        tick(2);
        adc_strobe(12'h111, 12'h222);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(3);
            adc_strobe(12'h333, 12'h444);
        end
        fifo_full = 1'b0;
        @(negedge clk);
        check("t4_ovf_during", overflow_cnt, 3);
        check("t4_q_held", exp_q.size(), 4);
        tick(3);
        @(negedge clk);
        check("t4_ovf", overflow_cnt, 3);
        adc_strobe(12'h555, 12'h666);
        tick(3);
        drain_check("t4_drain");
        check("t4_ovf_final", overflow_cnt, 3);

        // mode change mid-frame applies only to the next frame
        do_reset();
        Channel_Select = 2'b01;
        exp_q.push_back(16'hAA55);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h100A);
        exp_q.push_back(16'hAA55);
        exp_q.push_back(16'h200B);
        tick(2);
        for (int i = 0; i < 5; i++) begin
            adc_strobe(12'h00A, 12'h00B);
            tick(3);
            if (i == 0) Channel_Select = 2'b10;
        end
        drain_check("t5_drain");

        // clear pulse mid-frame, coincident with a strobe
        do_reset();
        Channel_Select = 2'b11;
        tick(1);
        fifo_full = 1'b1;
        adc_strobe(12'h001, 12'h002);
        @(negedge clk);
        check("t6_ovf_hdr", overflow_cnt, 1);
        check("t6_busy", busy, 1);
        fifo_full = 1'b0;
        exp_q.push_back(16'hAA55);
        exp_q.push_back(16'h1001);
        tick(1);
        adc_strobe(12'h001, 12'h002);
        tick(1);
        rst_fifo_req = 1'b1;
        adc_valid    = 1'b1;
        tick(1);
        rst_fifo_req = 1'b0;
        adc_valid    = 1'b0;
        @(negedge clk);
        check("t6_clr_wr_en", fifo_wr_en, 0);
        check("t6_clr_busy", busy, 0);
        check("t6_clr_ovf", overflow_cnt, 0);
        check("t6_q_before", exp_q.size(), 0);
        exp_q.push_back(16'hAA55);
        tick(3);
        drain_check("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_data_packer.md
Name: adc_data_packer

Overview:
- Stage directly downstream of the USB command interpreter, on the same clk domain.
- Takes Channel_Select and the clear-FIFO pulse from the interpreter, plus raw sample strobes from the dual-channel 12-bit ADC front end.
- Packs the samples into tagged 16-bit words and frames them with a header.
- Writes the frames into the USB upload data FIFO, handling backpressure and counting dropped samples.

Parameters:
- ADC_WIDTH, 12, bits per ADC sample; must be ≤ 12 so the 4-bit tag fits.
- FRAME_LEN, 256, samples (ADC strobes) per frame; must be ≥ 2.
- HEADER_WORD, 16'hAA55, first word of every frame.

Ports:
- clk  input  1  system clock (rising edge).
- reset_n  input  1  synchronous active-low reset.
- Channel_Select  input  2  from interpreter: 00 off, 01 ch1, 10 ch2, 11 both.
- rst_fifo_req  input  1  from interpreter (out_to_rst_all_fifo); one-cycle clear pulse.
- adc_valid  input  1  one-cycle strobe, both samples valid; at most once per 4 clk.
- adc_ch1_data  input  ADC_WIDTH  channel 1 sample.
- adc_ch2_data  input  ADC_WIDTH  channel 2 sample.
- fifo_full  input  1  data FIFO almost-full; asserted with ≥1 free entry remaining.
- fifo_wr_en  output  1  registered write strobe to the data FIFO.
- fifo_din  output  16  registered write data.
- overflow_cnt  output  16  saturating count of dropped samples.
- busy  output  1  high whenever state ≠ S_IDLE.

Behaviour:
- Reset and clear:
  - Reset (reset_n=0 at a clk edge): state=S_IDLE, fifo_wr_en=0, fifo_din=0, overflow_cnt=0, sample counter=0, latched mode=00, busy=0.
  - rst_fifo_req=1: same effect as reset on that edge. reset_n has priority; an abandoned partial frame is never resumed.
- Word format:
  - Ch1 word = {4'h1, zero-pad, ch1 sample}.
  - Ch2 word = {4'h2, zero-pad, ch2 sample}.
  - Samples are right-aligned, zero-extended to 12 bits.
- Output timing: fifo_wr_en and fifo_din are registered. The decision is made on fifo_full at edge t; the write is visible in cycle t+1. Nothing is written while fifo_full=1.
- S_IDLE:
  - mode ← Channel_Select every cycle.
  - If Channel_Select ≠ 00 → S_HDR.
  - adc_valid is ignored and not counted.
- S_HDR: if !fifo_full, write HEADER_WORD, clear sample counter, → S_WAIT; else stay.
- S_WAIT: on adc_valid, capture both samples into holding registers → S_CH1 if mode[0], else S_CH2.
- S_CH1: if !fifo_full, write the ch1 word → S_CH2 if mode[1], else end-of-sample; else stay.
- S_CH2: if !fifo_full, write the ch2 word → end-of-sample; else stay.
- End-of-sample:
  - If counter == FRAME_LEN-1 → S_IDLE (re-latch mode; a new header follows next cycle if mode ≠ 00).
  - Otherwise increment counter → S_WAIT.
- Latency: adc_valid at edge N in S_WAIT → first data word at cycle N+1, second at N+2, when no stall occurs.
- Mode changes: mode is latched only in S_IDLE. A Channel_Select change mid-frame takes effect at the next frame. 00 mid-frame finishes the current frame, then the block idles.
- Overflow:
  - adc_valid in S_HDR, S_CH1 or S_CH2 drops that sample; overflow_cnt += 1, saturating at 16'hFFFF.
  - Held samples are never overwritten.
- Simultaneous events:
  - adc_valid on the same edge as end-of-sample (transition into S_WAIT) counts as overflow.
  - rst_fifo_req with adc_valid: the clear wins; no count.

Decomposition:
- Shared package daq_pkg holds:
  - the state enum (S_IDLE, S_HDR, S_WAIT, S_CH1, S_CH2);
  - TAG_CH1=4'h1, TAG_CH2=4'h2;
  - default HEADER_WORD;
  - CH_OFF/CH1/CH2/CH_BOTH encodings (00/01/10/11), shared with the command interpreter.
- No sub-module is required. The saturating counter stays inline.

Test Plan:
- Select=01, FRAME_LEN=4, 4 strobes with ch1=0x123 → writes AA55, 1123×4; 5th strobe is preceded by a new AA55.
- Select=11, ch1=0x0AB, ch2=0xFFF, one strobe → AA55 then 10AB at N+1, 2FFF at N+2; overflow_cnt=0.
- Select=00, 100 strobes → fifo_wr_en never asserts; busy=0; overflow_cnt=0.
- Select=11, fifo_full held for 12 cycles starting in S_CH1, strobes every 4 cycles → 3 strobes dropped, overflow_cnt=3; the held sample is written after fifo_full falls; no word is lost or duplicated.
- Select switches 01→10 at sample 2 of a 4-sample frame → the remaining frame uses tag 1; the next frame has AA55 then tag-2 words only.
- rst_fifo_req pulse mid-frame → next cycle fifo_wr_en=0, busy re-evaluates from S_IDLE, overflow_cnt=0; the first subsequent write is AA55.
